serial_frame_receiver: RTL

- Parametrised successor to the fixed 784×16-bit serial image loader feeding the classifier.
- Receives a frame of NUM_WORDS words, WORD_WIDTH bits each, over an external two-wire link (serial clock + serial data from the Arduino header), asynchronous to CLOCK_50.
- Synchronises the link, deserialises with selectable bit order, and writes each word to the input-image RAM through a simple write port.
- Signals frame completion with a ready/ack handshake. Aborts and flags an error on an inter-bit timeout.

---
 rtl/serial_frame_receiver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Receives a frame of NUM_WORDS serial words from an asynchronous two-wire link.
// Each assembled word goes out on a RAM write port; frame_ready/frame_ack closes the frame.
module serial_frame_receiver #(
  parameter int WORD_WIDTH     = 16,
  parameter int NUM_WORDS      = 784,
  parameter int ADDR_WIDTH     = 10,
  parameter int MSB_FIRST      = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  serial_clk,
  input  logic                  serial_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_ready,
  input  logic                  frame_ack,
  output logic                  timeout_err,
  output logic                  overrun_err
);

  localparam int BCW = $clog2(WORD_WIDTH + 1);
  localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0]        LAST_BIT   = BCW'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ICW-1:0]        IDLE_LIMIT = ICW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_DONE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  clk_sync;
  logic [SYNC_STAGES-1:0]  data_sync;
  logic                    sync_clk_d;
  logic                    ser_edge;
  logic                    ser_bit;
  logic [BCW-1:0]          bit_cnt;
  logic [ADDR_WIDTH-1:0]   word_cnt;
  logic [ICW-1:0]          idle_cnt;
  logic [WORD_WIDTH-1:0]   shreg;

  function automatic logic [WORD_WIDTH-1:0] shift_in(input logic [WORD_WIDTH-1:0] cur,
                                                     input logic b);
    if (MSB_FIRST != 0) return {cur[WORD_WIDTH-2:0], b};
    else                return {b, cur[WORD_WIDTH-1:1]};
  endfunction

  // Equal depth on both paths keeps the sampled data aligned with the clock edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      sync_clk_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], serial_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], serial_data};
      sync_clk_d <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ser_edge = clk_sync[SYNC_STAGES-1] & ~sync_clk_d;
  assign ser_bit  = data_sync[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      shreg       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low each cycle so it can only ever be a single-cycle pulse.
      wr_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ser_edge && enable) begin
            state       <= S_RECEIVE;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            bit_cnt     <= BCW'(1);
            word_cnt    <= '0;
            idle_cnt    <= '0;
            shreg       <= shift_in('0, ser_bit);
          end
        end
        S_RECEIVE: begin
          if (ser_edge) begin
            idle_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              wr_en   <= 1'b1;
              wr_data <= shift_in(shreg, ser_bit);
              wr_addr <= word_cnt;
              bit_cnt <= '0;
              shreg   <= '0;
              if (word_cnt == LAST_WORD) begin
                state       <= S_DONE;
                busy        <= 1'b0;
                frame_ready <= 1'b1;
                word_cnt    <= '0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shift_in(shreg, ser_bit);
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            // Abort: words already written stay in RAM, the partial word is dropped.
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            idle_cnt    <= '0;
            shreg       <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (frame_ack) begin
            state       <= S_IDLE;
            frame_ready <= 1'b0;
            overrun_err <= ser_edge;
          end else if (ser_edge) begin
            overrun_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
